// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter among 4 byte requesters
//
// Picks one requester at a time and hands its byte to the UART TX with a one-cycle start pulse.
// The owner may send up to BURST_MAX bytes back-to-back. After that it is forced to rotate.
// Ports:
//   clk_i       clock, rising edge
//   rst_ni      asynchronous active-low reset
//   req_i       per-requester byte pending
//   data_i      packed bytes, byte i = data_i[i*DATA_W +: DATA_W]
//   ack_o       one-cycle pulse, byte of requester i accepted
//   tx_busy_i   UART TX busy flag
//   tx_start_o  one-cycle pulse loading tx_data_o into the UART TX
//   tx_data_o   byte to transmit, valid while tx_start_o=1
//   grant_o     one-hot current owner, 0 when idle
//   gnt_idx_o   binary owner index, holds last owner when idle
module uart_tx_arbiter #(
    parameter int DATA_W    = 8,
    parameter int BURST_MAX = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [3:0]          req_i,
    input  logic [4*DATA_W-1:0] data_i,
    output logic [3:0]          ack_o,
    input  logic                tx_busy_i,
    output logic                tx_start_o,
    output logic [DATA_W-1:0]   tx_data_o,
    output logic [3:0]          grant_o,
    output logic [1:0]          gnt_idx_o
);

    localparam int CNT_W = $clog2(BURST_MAX + 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_HI, WAIT_LO} state_e;

    state_e              state_q, state_d;
    logic [1:0]          ptr_q, ptr_d;
    logic [1:0]          idx_q, idx_d;
    logic [3:0]          grant_q, grant_d;
    logic [3:0]          ack_q, ack_d;
    logic                start_q, start_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [CNT_W-1:0]    burst_q, burst_d;

    logic                pick_found;
    logic [1:0]          pick_idx;
    logic [1:0]          cand;

    function automatic logic [DATA_W-1:0] byte_of(input logic [4*DATA_W-1:0] bus,
                                                  input logic [1:0] idx);
        return bus[int'(idx)*DATA_W +: DATA_W];
    endfunction

    // Scan from the farthest offset down to ptr so the nearest requester wins.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = ptr_q;
        cand       = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            cand = ptr_q + 2'(k);
            if (req_i[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // The start/ack/data pulse is registered on entry to SEND, so it is visible during SEND.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        grant_d = grant_q;
        ack_d   = 4'b0000;
        start_d = 1'b0;
        data_d  = data_q;
        burst_d = burst_q;
        unique case (state_q)
            IDLE: begin
                grant_d = 4'b0000;
                if (pick_found && !tx_busy_i) begin
                    idx_d   = pick_idx;
                    grant_d = 4'b0001 << pick_idx;
                    ack_d   = 4'b0001 << pick_idx;
                    start_d = 1'b1;
                    data_d  = byte_of(data_i, pick_idx);
                    burst_d = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                burst_d = burst_q + CNT_W'(1);
                state_d = WAIT_HI;
            end
            WAIT_HI: begin
                if (tx_busy_i) begin
                    state_d = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (!tx_busy_i) begin
                    if (req_i[idx_q] && (burst_q < CNT_W'(BURST_MAX))) begin
                        ack_d   = 4'b0001 << idx_q;
                        start_d = 1'b1;
                        data_d  = byte_of(data_i, idx_q);
                        state_d = SEND;
                    end else begin
                        grant_d = 4'b0000;
                        ptr_d   = idx_q + 2'd1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            idx_q   <= 2'd0;
            grant_q <= 4'b0000;
            ack_q   <= 4'b0000;
            start_q <= 1'b0;
            data_q  <= '0;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            start_q <= start_d;
            data_q  <= data_d;
            burst_q <= burst_d;
        end
    end

    assign ack_o      = ack_q;
    assign tx_start_o = start_q;
    assign tx_data_o  = data_q;
    assign grant_o    = grant_q;
    assign gnt_idx_o  = idx_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] data;
    logic        busy_force;
    logic        tx_busy;
    logic        sel;
    int          busy_len;
    int          busy_cnt;
    int          n_starts;
    int          n_cmp;
    int          n_bad;

    logic [3:0] ack_a, grant_a, ack_b, grant_b;
    logic [1:0] idx_a, idx_b;
    logic       start_a, start_b;
    logic [7:0] txd_a, txd_b;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.DATA_W(8), .BURST_MAX(4)) u_b4 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .data_i(data), .ack_o(ack_a),
        .tx_busy_i(tx_busy), .tx_start_o(start_a), .tx_data_o(txd_a),
        .grant_o(grant_a), .gnt_idx_o(idx_a)
    );

    uart_tx_arbiter #(.DATA_W(8), .BURST_MAX(1)) u_b1 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .data_i(data), .ack_o(ack_b),
        .tx_busy_i(tx_busy), .tx_start_o(start_b), .tx_data_o(txd_b),
        .grant_o(grant_b), .gnt_idx_o(idx_b)
    );

    wire [3:0] ack_s   = sel ? ack_b   : ack_a;
    wire [3:0] grant_s = sel ? grant_b : grant_a;
    wire [1:0] idx_s   = sel ? idx_b   : idx_a;
    wire       start_s = sel ? start_b : start_a;
    wire [7:0] txd_s   = sel ? txd_b   : txd_a;

    // UART TX model: busy for busy_len cycles after each start pulse.
    assign tx_busy = busy_force | (busy_cnt != 0);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)              busy_cnt <= 0;
        else if (start_s)        busy_cnt <= busy_len;
        else if (busy_cnt != 0)  busy_cnt <= busy_cnt - 1;
    end

    always @(posedge clk) begin
        if (start_s) n_starts <= n_starts + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_start(input string tag, input int max);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (start_s) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq({tag, "_start_seen"}, 32'(ok), 32'd1);
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        req        = 4'b0000;
        busy_force = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_owner(input string tag, input int exp_idx);
        logic [3:0] g;
        logic [7:0] b;
        g = 4'b0001 << exp_idx;
        b = data[exp_idx*8 +: 8];
        check_eq({tag, "_idx"},   32'(idx_s),   32'(exp_idx));
        check_eq({tag, "_grant"}, 32'(grant_s), 32'(g));
        check_eq({tag, "_ack"},   32'(ack_s),   32'(g));
        check_eq({tag, "_data"},  32'(txd_s),   32'(b));
    endtask

    int exp4 [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
    int s0;

    initial begin
        #500us;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0; n_bad = 0; n_starts = 0;
        sel = 1'b0; busy_len = 4; data = 32'h0; req = 4'b0; busy_force = 1'b0;
        rst_n = 1'b0;

        // Reset state and reset during SEND.
        repeat (2) @(negedge clk);
        check_eq("rst_grant", 32'(grant_s), 32'd0);
        check_eq("rst_idx",   32'(idx_s),   32'd0);
        check_eq("rst_ack",   32'(ack_s),   32'd0);
        check_eq("rst_start", 32'(start_s), 32'd0);
        check_eq("rst_data",  32'(txd_s),   32'd0);
        rst_n = 1'b1;
        data  = 32'h0000005A;
        req   = 4'b0001;
        wait_start("t1a", 10);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_grant", 32'(grant_s), 32'd0);
        check_eq("midrst_start", 32'(start_s), 32'd0);
        check_eq("midrst_ack",   32'(ack_s),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_start("t1b", 10);
        check_owner("t1_after", 0);

        // Single byte with exact latency and release timing.
        do_reset();
        busy_len = 10;
        data = 32'h000000A5;
        s0 = n_starts;
        req = 4'b0001;
        @(negedge clk);
        check_eq("t2_start", 32'(start_s), 32'd1);
        check_owner("t2", 0);
        req = 4'b0000;
        repeat (11) @(negedge clk);
        check_eq("t2_grant_held", 32'(grant_s), 32'b0001);
        @(negedge clk);
        check_eq("t2_grant_rel", 32'(grant_s), 32'd0);
        check_eq("t2_nstarts", 32'(n_starts - s0), 32'd1);

        // Round-robin with BURST_MAX=1.
        sel = 1'b1;
        do_reset();
        busy_len = 2;
        data = 32'h44332211;
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_start($sformatf("t3_%0d", i), 30);
            check_owner($sformatf("t3_%0d", i), i % 4);
        end

        // Bursts of 4 with BURST_MAX=4.
        sel = 1'b0;
        do_reset();
        busy_len = 2;
        data = 32'h44332211;
        req = 4'b0011;
        for (int i = 0; i < 9; i++) begin
            wait_start($sformatf("t4_%0d", i), 30);
            check_owner($sformatf("t4_%0d", i), exp4[i]);
        end

        // Busy gate.
        do_reset();
        busy_len = 3;
        s0 = n_starts;
        busy_force = 1'b1;
        req = 4'b0100;
        repeat (6) @(negedge clk);
        check_eq("t5_gated_grant", 32'(grant_s), 32'd0);
        check_eq("t5_gated_starts", 32'(n_starts - s0), 32'd0);
        busy_force = 1'b0;
        @(negedge clk);
        check_eq("t5_start", 32'(start_s), 32'd1);
        check_owner("t5", 2);

        // Early release, next winner ch0 (ch3 idle).
        do_reset();
        req = 4'b0100;
        wait_start("t6a_first", 10);
        check_owner("t6a_first", 2);
        req = 4'b0001;
        wait_start("t6a_next", 40);
        check_owner("t6a_next", 0);

        // Early release, next winner ch3.
        do_reset();
        req = 4'b0100;
        wait_start("t6b_first", 10);
        check_owner("t6b_first", 2);
        req = 4'b1001;
        wait_start("t6b_next", 40);
        check_owner("t6b_next", 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
